io_pwr_seq_ctrl: RTL and testbench
==================================

Name: io_pwr_seq_ctrl

Overview:
- Core-side digital controller for the 1.8 V IO ring power domain (VDDIO/VSSIO, pad well supply VPW).
- The IO supply pads provide power. This block observes IO supply-good status and drives the pad-ring control signals in a safe order:
  - isolation release, then retention release, then output enable on power-up;
  - the reverse order on power-down or supply loss.
- Sits in the always-on core domain between the power manager and the pad ring.

Parameters:
- SYNC_STAGES, 2, flops in the supply-good synchronizer (min 2).
- DLY_W, 8, width of the programmable step-delay counter.
- DLY_DEFAULT, 8'd16, step delay in clk cycles used when dly_cfg is 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- vddio_ok_a  in  1  asynchronous IO-supply-good from the supply detector.
- vpw_ok_a  in  1  asynchronous pad-well-supply-good.
- pwr_on_req  in  1  level request from the power manager: 1 = IO ring on.
- dly_cfg  in  DLY_W  cycles between sequence steps; 0 selects DLY_DEFAULT. Sampled on leaving OFF and on entering PD_OE.
- pad_iso_en  out  1  pad isolation, active high.
- pad_ret_en  out  1  pad retention, active high.
- pad_oe_en  out  1  global pad output enable.
- io_ready  out  1  IO ring fully on.
- io_fault  out  1  sticky supply-loss flag.
- fault_clr  in  1  single-cycle pulse that clears io_fault.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset values:
  - pad_iso_en=1, pad_ret_en=1, pad_oe_en=0, io_ready=0, io_fault=0.
  - state=OFF (3'd0), delay counter=0, synchronizers=0.
- Synchronizers:
  - vddio_ok_a and vpw_ok_a each pass through SYNC_STAGES flops.
  - supply_ok = vddio_ok_s & vpw_ok_s.
  - Latency from input edge to supply_ok is SYNC_STAGES cycles.
- Step delay counter:
  - Loaded with D = (dly_cfg==0 ? DLY_DEFAULT : dly_cfg) on entry to each timed state.
  - Decrements each cycle; the state exits on the cycle the counter reaches 0. Each timed state therefore lasts D+1 cycles.
- States and transitions:
  - OFF (0): iso=1, ret=1, oe=0. Go to WAIT_SUP when pwr_on_req & !io_fault.
  - WAIT_SUP (1): wait for supply_ok. Go to STAB (timed) when supply_ok=1. Go to OFF if pwr_on_req drops.
  - STAB (2): supply settle time. On expiry clear pad_iso_en and go to REL_RET.
  - REL_RET (3, timed): on expiry clear pad_ret_en and go to EN_OE.
  - EN_OE (4, timed): on expiry set pad_oe_en and go to ON.
  - ON (5): io_ready=1. When pwr_on_req=0, clear pad_oe_en and io_ready in the same cycle and go to PD_OE.
  - PD_OE (6, timed): on expiry set pad_ret_en and pad_iso_en together, then go to OFF.
- Ordering invariant: pad_oe_en=1 only if pad_iso_en=0 and pad_ret_en=0. This must hold on every cycle.
- Supply loss:
  - Trigger: supply_ok=0 in any state STAB through PD_OE.
  - Next edge: pad_oe_en=0, pad_ret_en=1, pad_iso_en=1, io_ready=0, io_fault=1, state=OFF. No delay is applied.
  - Supply loss takes priority over every other transition in the same cycle.
- Fault clearing:
  - io_fault stays set until fault_clr=1. Clearing is ignored while supply_ok=0.
  - While io_fault=1 the block stays in OFF regardless of pwr_on_req.
- Request toggles:
  - pwr_on_req deasserted during STAB, REL_RET or EN_OE: abort to PD_OE. pad_oe_en is already 0 at that point.
  - pwr_on_req reasserted during PD_OE: ignored until OFF is reached; the sequence then restarts from WAIT_SUP.
- rst asserted mid-sequence: all outputs return to their reset values on the next edge.
- dly_cfg changes inside a timed state take effect only on the next load of the counter.

Test Plan:
- Power-up: rst, then vddio_ok_a=vpw_ok_a=1, pwr_on_req=1, dly_cfg=4.
  - pad_iso_en falls 5 cycles after STAB entry.
  - pad_ret_en falls 5 cycles later; pad_oe_en and io_ready rise 5 cycles after that.
  - State codes are 1,2,3,4,5.
- Power-down from ON (dly_cfg=4): drop pwr_on_req.
  - pad_oe_en=0 next edge.
  - 5 cycles later iso=ret=1 and state=OFF.
- Default delay: dly_cfg=0.
  - Each timed step lasts 17 cycles.
  - Total from supply_ok to io_ready is 51 cycles plus 1 cycle to leave WAIT_SUP.
- Supply loss in ON: vpw_ok_a=0.
  - After SYNC_STAGES+1 edges: oe=0, iso=ret=1, io_fault=1, state=0.
  - pwr_on_req held at 1 does not restart the sequence.
  - fault_clr with supplies good clears io_fault, then the sequence restarts.
- Abort: drop pwr_on_req during REL_RET.
  - State goes to PD_OE and pad_oe_en never asserts.
  - Ordering invariant checked by assertion over all tests.
- Reset mid-EN_OE: assert rst for 1 cycle.
  - Next edge: iso=1, ret=1, oe=0, io_ready=0, io_fault=0, state=0.

Source files
------------

// File: rtl/io_pwr_seq_ctrl.sv
// IO-ring power sequencer: orders pad isolation, retention and output-enable
// against synchronized supply-good status, with sticky supply-loss handling.
module io_pwr_seq_ctrl #(
    parameter int                SYNC_STAGES = 2,
    parameter int                DLY_W       = 8,
    parameter logic [DLY_W-1:0]  DLY_DEFAULT = 8'd16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vddio_ok_a,
    input  logic             vpw_ok_a,
    input  logic             pwr_on_req,
    input  logic [DLY_W-1:0] dly_cfg,
    output logic             pad_iso_en,
    output logic             pad_ret_en,
    output logic             pad_oe_en,
    output logic             io_ready,
    output logic             io_fault,
    input  logic             fault_clr,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_WAIT_SUP = 3'd1,
        ST_STAB     = 3'd2,
        ST_REL_RET  = 3'd3,
        ST_EN_OE    = 3'd4,
        ST_ON       = 3'd5,
        ST_PD_OE    = 3'd6
    } state_t;

    localparam logic [DLY_W-1:0] DLY_ONE = {{(DLY_W-1){1'b0}}, 1'b1};

    function automatic logic [DLY_W-1:0] sel_dly(input logic [DLY_W-1:0] cfg);
        return (cfg == '0) ? DLY_DEFAULT : cfg;
    endfunction

    state_t                 state_q;
    logic [DLY_W-1:0]       cnt_q;
    logic [DLY_W-1:0]       cfg_q;
    logic [SYNC_STAGES-1:0] vddio_sync_q;
    logic [SYNC_STAGES-1:0] vpw_sync_q;
    logic                   iso_q;
    logic                   ret_q;
    logic                   oe_q;
    logic                   ready_q;
    logic                   fault_q;

    logic                   supply_ok_s;
    logic                   supply_lost_s;
    logic                   cnt_zero_s;
    logic [DLY_W-1:0]       dly_d;

    // Supply-good synchronizers, one shift chain per supply
    always_ff @(posedge clk) begin
        if (rst) begin
            vddio_sync_q <= '0;
            vpw_sync_q   <= '0;
        end else begin
            vddio_sync_q <= {vddio_sync_q[SYNC_STAGES-2:0], vddio_ok_a};
            vpw_sync_q   <= {vpw_sync_q[SYNC_STAGES-2:0], vpw_ok_a};
        end
    end

    // Supply status, step-delay selection and loss detection
    always_comb begin
        supply_ok_s   = vddio_sync_q[SYNC_STAGES-1] & vpw_sync_q[SYNC_STAGES-1];
        dly_d         = sel_dly(dly_cfg);
        cnt_zero_s    = (cnt_q == '0);
        if ((state_q == ST_OFF) || (state_q == ST_WAIT_SUP)) begin
            supply_lost_s = 1'b0;
        end else begin
            supply_lost_s = ~supply_ok_s;
        end
    end

    // Sequencer FSM with registered pad controls; supply loss overrides all
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            cfg_q   <= '0;
            iso_q   <= 1'b1;
            ret_q   <= 1'b1;
            oe_q    <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (supply_lost_s) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            iso_q   <= 1'b1;
            ret_q   <= 1'b1;
            oe_q    <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b1;
        end else begin
            if (fault_clr && supply_ok_s) begin
                fault_q <= 1'b0;
            end
            case (state_q)
                ST_OFF: begin
                    if (pwr_on_req && !fault_q) begin
                        state_q <= ST_WAIT_SUP;
                        cfg_q   <= dly_d;
                    end
                end
                ST_WAIT_SUP: begin
                    if (!pwr_on_req) begin
                        state_q <= ST_OFF;
                    end else if (supply_ok_s) begin
                        state_q <= ST_STAB;
                        cnt_q   <= cfg_q;
                    end
                end
                ST_STAB, ST_REL_RET, ST_EN_OE: begin
                    // Abort path: oe is still low here, so only iso/ret need restoring
                    if (!pwr_on_req) begin
                        state_q <= ST_PD_OE;
                        cnt_q   <= dly_d;
                        cfg_q   <= dly_d;
                        oe_q    <= 1'b0;
                    end else if (!cnt_zero_s) begin
                        cnt_q <= cnt_q - DLY_ONE;
                    end else if (state_q == ST_STAB) begin
                        iso_q   <= 1'b0;
                        state_q <= ST_REL_RET;
                        cnt_q   <= cfg_q;
                    end else if (state_q == ST_REL_RET) begin
                        ret_q   <= 1'b0;
                        state_q <= ST_EN_OE;
                        cnt_q   <= cfg_q;
                    end else begin
                        oe_q    <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= ST_ON;
                    end
                end
                ST_ON: begin
                    if (!pwr_on_req) begin
                        oe_q    <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= ST_PD_OE;
                        cnt_q   <= dly_d;
                        cfg_q   <= dly_d;
                    end
                end
                ST_PD_OE: begin
                    if (cnt_zero_s) begin
                        iso_q   <= 1'b1;
                        ret_q   <= 1'b1;
                        state_q <= ST_OFF;
                    end else begin
                        cnt_q <= cnt_q - DLY_ONE;
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    cnt_q   <= '0;
                    iso_q   <= 1'b1;
                    ret_q   <= 1'b1;
                    oe_q    <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign pad_iso_en = iso_q;
    assign pad_ret_en = ret_q;
    assign pad_oe_en  = oe_q;
    assign io_ready   = ready_q;
    assign io_fault   = fault_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_io_pwr_seq_ctrl.sv
// Directed bench for io_pwr_seq_ctrl: sequencing, delays, supply loss, abort,
// reset and a per-cycle ordering check (oe only with iso and ret released).
module tb_io_pwr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       vddio_ok_a;
    logic       vpw_ok_a;
    logic       pwr_on_req;
    logic [7:0] dly_cfg;
    logic       pad_iso_en;
    logic       pad_ret_en;
    logic       pad_oe_en;
    logic       io_ready;
    logic       io_fault;
    logic       fault_clr;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    io_pwr_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .vddio_ok_a (vddio_ok_a),
        .vpw_ok_a   (vpw_ok_a),
        .pwr_on_req (pwr_on_req),
        .dly_cfg    (dly_cfg),
        .pad_iso_en (pad_iso_en),
        .pad_ret_en (pad_ret_en),
        .pad_oe_en  (pad_oe_en),
        .io_ready   (io_ready),
        .io_fault   (io_fault),
        .fault_clr  (fault_clr),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [2:0] st, input logic iso,
                              input logic ret, input logic oe, input logic rdy, input logic flt);
        check_eq({tag, ".state"}, {29'd0, state_o}, {29'd0, st});
        check_eq({tag, ".iso"},   {31'd0, pad_iso_en}, {31'd0, iso});
        check_eq({tag, ".ret"},   {31'd0, pad_ret_en}, {31'd0, ret});
        check_eq({tag, ".oe"},    {31'd0, pad_oe_en},  {31'd0, oe});
        check_eq({tag, ".rdy"},   {31'd0, io_ready},   {31'd0, rdy});
        check_eq({tag, ".flt"},   {31'd0, io_fault},   {31'd0, flt});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output enable must never be high while isolation or retention is active
    always @(negedge clk) begin
        check_eq("order", {31'd0, pad_oe_en & (pad_iso_en | pad_ret_en)}, 32'd0);
    end

    initial begin
        rst        = 1'b1;
        vddio_ok_a = 1'b1;
        vpw_ok_a   = 1'b1;
        pwr_on_req = 1'b0;
        dly_cfg    = 8'd4;
        fault_clr  = 1'b0;
        step(2);
        expect_all("reset", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(3);

        // Power-up with 5-cycle steps
        pwr_on_req = 1'b1;
        step(1); expect_all("pu.wait", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1); expect_all("pu.stab", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4); expect_all("pu.stab_end", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1); expect_all("pu.relret", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4); expect_all("pu.relret_end", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1); expect_all("pu.enoe", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4); expect_all("pu.enoe_end", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1); expect_all("pu.on", 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Power-down from ON
        pwr_on_req = 1'b0;
        step(1); expect_all("pd.pdoe", 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4); expect_all("pd.pdoe_end", 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1); expect_all("pd.off", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Default delay: 17-cycle steps
        dly_cfg    = 8'd0;
        pwr_on_req = 1'b1;
        step(1);  check_eq("dd.wait", {29'd0, state_o}, 32'd1);
        step(1);  check_eq("dd.stab", {29'd0, state_o}, 32'd2);
        step(16); check_eq("dd.stab_end", {29'd0, state_o}, 32'd2);
        step(1);  check_eq("dd.relret", {29'd0, state_o}, 32'd3);
        step(16); check_eq("dd.relret_end", {29'd0, state_o}, 32'd3);
        step(1);  check_eq("dd.enoe", {29'd0, state_o}, 32'd4);
        step(16); expect_all("dd.enoe_end", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);  expect_all("dd.on", 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Supply loss in ON, with request held
        vpw_ok_a = 1'b0;
        step(2); expect_all("sl.sync", 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1); expect_all("sl.fault", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(5); expect_all("sl.hold", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        vpw_ok_a  = 1'b1;
        fault_clr = 1'b1;
        step(1); fault_clr = 1'b0;
        check_eq("sl.clr_ignored", {31'd0, io_fault}, 32'd1);
        step(3); expect_all("sl.still", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        fault_clr = 1'b1;
        step(1); fault_clr = 1'b0;
        expect_all("sl.cleared", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1); check_eq("sl.restart", {29'd0, state_o}, 32'd1);
        step(1); check_eq("sl.stab", {29'd0, state_o}, 32'd2);

        // Abort during REL_RET, then request reasserted during PD_OE
        step(16); check_eq("ab.stab_end", {29'd0, state_o}, 32'd2);
        step(1);  check_eq("ab.relret", {29'd0, state_o}, 32'd3);
        dly_cfg    = 8'd4;
        pwr_on_req = 1'b0;
        step(1); expect_all("ab.pdoe", 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pwr_on_req = 1'b1;
        step(3); expect_all("ab.pdoe_hold", 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1); check_eq("ab.pdoe_last", {29'd0, state_o}, 32'd6);
        step(1); expect_all("ab.off", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1); check_eq("ab.restart", {29'd0, state_o}, 32'd1);

        // Reset mid-EN_OE
        step(1); check_eq("rm.stab", {29'd0, state_o}, 32'd2);
        step(5); check_eq("rm.relret", {29'd0, state_o}, 32'd3);
        step(5); check_eq("rm.enoe", {29'd0, state_o}, 32'd4);
        step(2);
        rst = 1'b1;
        step(1); expect_all("rm.reset", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst        = 1'b0;
        pwr_on_req = 1'b0;

        // WAIT_SUP returns to OFF when the request drops before supplies are good
        vddio_ok_a = 1'b0;
        step(1);
        pwr_on_req = 1'b1;
        step(1); check_eq("ws.wait", {29'd0, state_o}, 32'd1);
        step(3); check_eq("ws.hold", {29'd0, state_o}, 32'd1);
        pwr_on_req = 1'b0;
        step(1); expect_all("ws.off", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
